// File: rtl/psum_allreduce_if.sv
// Handshake bundle between the core array and the partial-sum all-reduce unit.
interface psum_allreduce_if #(
    parameter int N_CORE = 2,
    parameter int SUM_BW = 23
);
    localparam int OUT_BW = SUM_BW + $clog2(N_CORE);

    logic [N_CORE-1:0]        in_valid;
    logic [N_CORE*SUM_BW-1:0] in_data;
    logic [N_CORE-1:0]        in_ready;
    logic [N_CORE-1:0]        out_valid;
    logic [OUT_BW-1:0]        out_data;
    logic [N_CORE-1:0]        out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/psum_allreduce.sv
// N-core partial-sum all-reduce: per-core FIFOs, lockstep pop, SUM/MAX reduction,
// result broadcast with independent per-core acknowledge.
module psum_allreduce #(
    parameter int N_CORE = 2,
    parameter int SUM_BW = 23,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    psum_allreduce_if.slave       bus,
    output logic                  busy,
    output logic [7:0]            round_cnt
);
    localparam int OUT_BW = SUM_BW + $clog2(N_CORE);
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;

    typedef enum logic [1:0] {IDLE, CALC, BCAST} state_t;

    state_t state, state_next;

    logic [SUM_BW-1:0] mem    [N_CORE][DEPTH];
    logic [PW-1:0]     rd_ptr [N_CORE];
    logic [PW-1:0]     wr_ptr [N_CORE];
    logic [CW-1:0]     count  [N_CORE];

    logic [N_CORE-1:0] push, ready, not_empty;
    logic              pop, load, done;

    logic [SUM_BW-1:0] ops [N_CORE];
    logic              mode_q;
    logic [OUT_BW-1:0] result, ext, out_data_q;
    logic [N_CORE-1:0] out_valid_q, valid_next;

    always_comb begin
        ready     = '0;
        push      = '0;
        not_empty = '0;
        for (int unsigned i = 0; i < N_CORE; i++) begin
            ready[i]     = reset && (count[i] != CW'(DEPTH));
            push[i]      = bus.in_valid[i] & ready[i];
            not_empty[i] = (count[i] != '0);
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state != IDLE);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        done       = 1'b0;
        valid_next = out_valid_q & ~bus.out_ready;
        case (state)
            IDLE: begin
                if (&not_empty) begin
                    pop        = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                load       = 1'b1;
                state_next = BCAST;
            end
            BCAST: begin
                if (valid_next == '0) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are sign-extended to OUT_BW so the N-way sum cannot overflow.
    always_comb begin
        ext    = '0;
        result = {{(OUT_BW-SUM_BW){ops[0][SUM_BW-1]}}, ops[0]};
        for (int unsigned i = 1; i < N_CORE; i++) begin
            ext = {{(OUT_BW-SUM_BW){ops[i][SUM_BW-1]}}, ops[i]};
            if (mode_q) begin
                if ($signed(ext) > $signed(result))
                    result = ext;
            end else begin
                result = result + ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_CORE; i++) begin
            if (push[i])
                mem[i][wr_ptr[i]] <= bus.in_data[i*SUM_BW +: SUM_BW];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_CORE; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CORE; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop)
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({push[i], pop})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mode_q      <= 1'b0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            round_cnt   <= '0;
            for (int unsigned i = 0; i < N_CORE; i++)
                ops[i] <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                mode_q <= mode;
                for (int unsigned i = 0; i < N_CORE; i++)
                    ops[i] <= mem[i][rd_ptr[i]];
            end
            if (load) begin
                out_data_q  <= result;
                out_valid_q <= '1;
            end else if (state == BCAST) begin
                out_valid_q <= valid_next;
            end
            if (done)
                round_cnt <= round_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_psum_allreduce.sv
// Directed bench for psum_allreduce: a 2-core and a 4-core instance on one clock.
module tb_psum_allreduce;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mode = 1'b0;
    logic mode4 = 1'b0;
    logic busy2, busy4;
    logic [7:0] rc2, rc4;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    psum_allreduce_if #(.N_CORE(2), .SUM_BW(23)) bus2 ();
    psum_allreduce_if #(.N_CORE(4), .SUM_BW(23)) bus4 ();

    psum_allreduce #(.N_CORE(2), .SUM_BW(23), .DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .mode(mode), .bus(bus2.slave),
        .busy(busy2), .round_cnt(rc2)
    );

    psum_allreduce #(.N_CORE(4), .SUM_BW(23), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .mode(mode4), .bus(bus4.slave),
        .busy(busy4), .round_cnt(rc4)
    );

    task automatic push2(input logic [22:0] a0, input logic [22:0] a1);
        bus2.in_data  = {a1, a0};
        bus2.in_valid = 2'b11;
        @(negedge clk);
        bus2.in_valid = 2'b00;
    endtask

    task automatic wait_bcast2(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus2.out_valid != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack2;
        bus2.out_ready = 2'b11;
        @(negedge clk);
        bus2.out_ready = 2'b00;
    endtask

    task automatic test_reset;
        bus2.in_valid = '0; bus2.in_data = '0; bus2.out_ready = '0;
        bus4.in_valid = '0; bus4.in_data = '0; bus4.out_ready = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0h expected 0", busy2); end
        tests++; if (bus2.out_valid !== 2'b00) begin fails++; $display("FAIL reset_out_valid: got %0h expected 0", bus2.out_valid); end
        tests++; if (bus2.in_ready !== 2'b00) begin fails++; $display("FAIL reset_in_ready: got %0h expected 0", bus2.in_ready); end
        tests++; if (bus2.out_data !== 24'd0) begin fails++; $display("FAIL reset_out_data: got %0h expected 0", bus2.out_data); end
        tests++; if (rc2 !== 8'd0) begin fails++; $display("FAIL reset_round_cnt: got %0d expected 0", rc2); end
        tests++; if (bus4.in_ready !== 4'h0) begin fails++; $display("FAIL reset_in_ready4: got %0h expected 0", bus4.in_ready); end
        reset = 1'b1;
        @(negedge clk);
        tests++; if (bus2.in_ready !== 2'b11) begin fails++; $display("FAIL release_in_ready: got %0h expected 3", bus2.in_ready); end
        tests++; if (bus4.in_ready !== 4'hF) begin fails++; $display("FAIL release_in_ready4: got %0h expected f", bus4.in_ready); end
    endtask

    task automatic test_sum_latency;
        mode = 1'b0;
        bus2.in_data  = {23'(-30), 23'(100)};
        bus2.in_valid = 2'b11;
        @(negedge clk);
        bus2.in_valid = 2'b00;
        tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL lat_t_busy: got %0h expected 0", busy2); end
        @(negedge clk);
        tests++; if (busy2 !== 1'b1 || bus2.out_valid !== 2'b00) begin fails++; $display("FAIL lat_t1: got busy=%0h ov=%0h expected busy=1 ov=0", busy2, bus2.out_valid); end
        @(negedge clk);
        tests++; if (bus2.out_valid !== 2'b11) begin fails++; $display("FAIL lat_t2_valid: got %0h expected 3", bus2.out_valid); end
        tests++; if (bus2.out_data !== 24'd70) begin fails++; $display("FAIL sum_100_m30: got %0h expected 46", bus2.out_data); end
        ack2();
        tests++; if (bus2.out_valid !== 2'b00 || busy2 !== 1'b0) begin fails++; $display("FAIL ack_idle: got ov=%0h busy=%0h expected 0 0", bus2.out_valid, busy2); end
        tests++; if (rc2 !== 8'd1) begin fails++; $display("FAIL round_cnt_1: got %0d expected 1", rc2); end
    endtask

    task automatic test_max;
        bit ok;
        mode = 1'b1;
        push2(23'(-5), 23'(-9));
        wait_bcast2(ok);
        tests++; if (!ok) begin fails++; $display("FAIL max_timeout: got none expected out_valid"); end
        tests++; if (bus2.out_data !== 24'hFFFFFB) begin fails++; $display("FAIL max_m5_m9: got %0h expected fffffb", bus2.out_data); end
        ack2();
        mode = 1'b0;
        push2(23'(-5), 23'(-9));
        wait_bcast2(ok);
        tests++; if (!ok) begin fails++; $display("FAIL sumneg_timeout: got none expected out_valid"); end
        tests++; if (bus2.out_data !== 24'hFFFFF2) begin fails++; $display("FAIL sum_m5_m9: got %0h expected fffff2", bus2.out_data); end
        ack2();
        tests++; if (rc2 !== 8'd3) begin fails++; $display("FAIL round_cnt_3: got %0d expected 3", rc2); end
    endtask

    task automatic test_staggered_ack;
        bit ok;
        push2(23'd7, 23'd8);
        wait_bcast2(ok);
        tests++; if (!ok) begin fails++; $display("FAIL stag_timeout: got none expected out_valid"); end
        bus2.out_ready = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++; if (bus2.out_valid !== 2'b10) begin fails++; $display("FAIL stag_valid: got %0h expected 2", bus2.out_valid); end
            tests++; if (bus2.out_data !== 24'd15 || busy2 !== 1'b1) begin fails++; $display("FAIL stag_hold: got data=%0h busy=%0h expected f 1", bus2.out_data, busy2); end
            tests++; if (rc2 !== 8'd3) begin fails++; $display("FAIL stag_cnt_early: got %0d expected 3", rc2); end
        end
        bus2.out_ready = 2'b11;
        @(negedge clk);
        bus2.out_ready = 2'b00;
        tests++; if (bus2.out_valid !== 2'b00 || rc2 !== 8'd4) begin fails++; $display("FAIL stag_done: got ov=%0h cnt=%0d expected 0 4", bus2.out_valid, rc2); end
    endtask

    task automatic test_backpressure;
        logic [23:0] exp_res [5];
        logic [23:0] got_res [5];
        logic [22:0] c1_vals [5];
        int nres, i1;
        bit prev0, prev1;
        exp_res = '{24'd11, 24'd22, 24'd33, 24'd44, 24'd55};
        c1_vals = '{23'd10, 23'd20, 23'd30, 23'd40, 23'd50};
        for (int v = 1; v <= 4; v++) begin
            tests++; if (bus2.in_ready[0] !== 1'b1) begin fails++; $display("FAIL bp_ready_before_%0d: got %0h expected 1", v, bus2.in_ready[0]); end
            bus2.in_data[22:0] = 23'(v);
            bus2.in_valid[0]   = 1'b1;
            @(negedge clk);
        end
        bus2.in_data[22:0] = 23'd5;
        tests++; if (bus2.in_ready[0] !== 1'b0) begin fails++; $display("FAIL bp_full: got %0h expected 0", bus2.in_ready[0]); end
        @(negedge clk);
        tests++; if (bus2.in_ready[0] !== 1'b0 || busy2 !== 1'b0) begin fails++; $display("FAIL bp_hold: got rdy=%0h busy=%0h expected 0 0", bus2.in_ready[0], busy2); end
        bus2.out_ready = 2'b11;
        i1 = 0;
        bus2.in_data[45:23] = c1_vals[0];
        bus2.in_valid[1]    = 1'b1;
        prev0 = bus2.in_valid[0] & bus2.in_ready[0];
        prev1 = bus2.in_valid[1] & bus2.in_ready[1];
        nres = 0;
        for (int cyc = 0; cyc < 100 && nres < 5; cyc++) begin
            @(negedge clk);
            if (bus2.out_valid == 2'b11) begin
                got_res[nres] = bus2.out_data;
                nres++;
            end
            if (prev0) bus2.in_valid[0] = 1'b0;
            if (prev1) begin
                i1++;
                if (i1 < 5) bus2.in_data[45:23] = c1_vals[i1];
                else bus2.in_valid[1] = 1'b0;
            end
            prev0 = bus2.in_valid[0] & bus2.in_ready[0];
            prev1 = bus2.in_valid[1] & bus2.in_ready[1];
        end
        tests++; if (nres != 5) begin fails++; $display("FAIL bp_result_count: got %0d expected 5", nres); end
        for (int r = 0; r < nres; r++) begin
            tests++; if (got_res[r] !== exp_res[r]) begin fails++; $display("FAIL bp_result_%0d: got %0d expected %0d", r, got_res[r], exp_res[r]); end
        end
        @(negedge clk);
        bus2.out_ready = 2'b00;
        bus2.in_valid  = 2'b00;
        tests++; if (rc2 !== 8'd9) begin fails++; $display("FAIL bp_round_cnt: got %0d expected 9", rc2); end
    endtask

    task automatic test_four_core;
        bit ok;
        mode4 = 1'b0;
        bus4.in_data  = {4{23'h400000}};
        bus4.in_valid = 4'hF;
        @(negedge clk);
        bus4.in_valid = 4'h0;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (bus4.out_valid != 4'h0) ok = 1'b1;
        end
        tests++; if (bus4.out_valid !== 4'hF) begin fails++; $display("FAIL n4_valid: got %0h expected f", bus4.out_valid); end
        tests++; if (bus4.out_data !== 25'h1000000) begin fails++; $display("FAIL n4_sum_min: got %0h expected 1000000", bus4.out_data); end
        bus4.out_ready = 4'hF;
        @(negedge clk);
        bus4.out_ready = 4'h0;
        tests++; if (rc4 !== 8'd1 || busy4 !== 1'b0) begin fails++; $display("FAIL n4_done: got cnt=%0d busy=%0h expected 1 0", rc4, busy4); end
        mode4 = 1'b1;
        bus4.in_data  = {23'd7, 23'd7, 23'(-1), 23'd3};
        bus4.in_valid = 4'hF;
        @(negedge clk);
        bus4.in_valid = 4'h0;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (bus4.out_valid != 4'h0) ok = 1'b1;
        end
        tests++; if (bus4.out_data !== 25'd7) begin fails++; $display("FAIL n4_max: got %0h expected 7", bus4.out_data); end
        bus4.out_ready = 4'hF;
        @(negedge clk);
        bus4.out_ready = 4'h0;
    endtask

    task automatic test_reset_midround;
        bit ok;
        mode = 1'b0;
        push2(23'd1, 23'd2);
        push2(23'd3, 23'd4);
        wait_bcast2(ok);
        tests++; if (bus2.out_valid !== 2'b11) begin fails++; $display("FAIL mid_bcast: got %0h expected 3", bus2.out_valid); end
        reset = 1'b0;
        #1;
        tests++; if (bus2.out_valid !== 2'b00 || bus2.in_ready !== 2'b00) begin fails++; $display("FAIL mid_reset: got ov=%0h rdy=%0h expected 0 0", bus2.out_valid, bus2.in_ready); end
        tests++; if (busy2 !== 1'b0 || rc2 !== 8'd0) begin fails++; $display("FAIL mid_reset_state: got busy=%0h cnt=%0d expected 0 0", busy2, rc2); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++; if (bus2.in_ready !== 2'b11 || rc2 !== 8'd0) begin fails++; $display("FAIL mid_release: got rdy=%0h cnt=%0d expected 3 0", bus2.in_ready, rc2); end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            tests++; if (bus2.out_valid !== 2'b00 || busy2 !== 1'b0) begin fails++; $display("FAIL mid_no_stale: got ov=%0h busy=%0h expected 0 0", bus2.out_valid, busy2); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sum_latency();
        test_max();
        test_staggered_ack();
        test_backpressure();
        test_four_core();
        test_reset_midround();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
